// File: rtl/nac_axi_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : nac_axi_mem_arbiter
// Brief    : two-master AXI4 arbiter sharing the DDR3 controller slave port
// Revision : 1.0 - initial release
// ============================================================================
module nac_axi_mem_arbiter #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int APL = AW + 13,
  parameter int WPL = DW + DW / 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             excl_m0,
  // master-side write address
  input  logic [2*APL-1:0] s_aw_pl,
  input  logic [1:0]       s_awvalid,
  output logic [1:0]       s_awready,
  // master-side write data
  input  logic [2*WPL-1:0] s_w_pl,
  input  logic [1:0]       s_wlast,
  input  logic [1:0]       s_wvalid,
  output logic [1:0]       s_wready,
  // master-side write response
  output logic [1:0]       s_bresp,
  output logic [1:0]       s_bvalid,
  input  logic [1:0]       s_bready,
  // master-side read address
  input  logic [2*APL-1:0] s_ar_pl,
  input  logic [1:0]       s_arvalid,
  output logic [1:0]       s_arready,
  // master-side read data
  output logic [DW-1:0]    s_rdata,
  output logic [1:0]       s_rresp,
  output logic             s_rlast,
  output logic [1:0]       s_rvalid,
  input  logic [1:0]       s_rready,
  // slave-side write address
  output logic [APL-1:0]   m_aw_pl,
  output logic             m_awvalid,
  input  logic             m_awready,
  // slave-side write data
  output logic [WPL-1:0]   m_w_pl,
  output logic             m_wlast,
  output logic             m_wvalid,
  input  logic             m_wready,
  // slave-side write response
  input  logic [1:0]       m_bresp,
  input  logic             m_bvalid,
  output logic             m_bready,
  // slave-side read address
  output logic [APL-1:0]   m_ar_pl,
  output logic             m_arvalid,
  input  logic             m_arready,
  // slave-side read data
  input  logic [DW-1:0]    m_rdata,
  input  logic [1:0]       m_rresp,
  input  logic             m_rlast,
  input  logic             m_rvalid,
  output logic             m_rready,
  // status
  output logic [1:0]       wr_grant,
  output logic [1:0]       rd_grant,
  output logic             proto_err
);

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_ADDR = 2'd1;
  localparam logic [1:0] W_DATA = 2'd2;
  localparam logic [1:0] W_RESP = 2'd3;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_ADDR = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  logic [1:0]     r_wr_state;
  logic [1:0]     w_wr_state_nxt;
  logic [1:0]     r_rd_state;
  logic [1:0]     w_rd_state_nxt;

  // owner doubles as the round-robin pointer: it always names the last winner
  logic           r_wr_owner;
  logic           r_rd_owner;
  logic [1:0]     r_wr_grant;
  logic [1:0]     r_rd_grant;
  logic [7:0]     r_wr_len;
  logic [7:0]     r_wr_cnt;
  logic           r_proto_err;

  logic [1:0]     w_elig;
  logic [1:0]     w_aw_req;
  logic [1:0]     w_ar_req;
  logic           w_wr_win;
  logic           w_rd_win;
  logic           w_aw_hs;
  logic           w_w_hs;
  logic           w_b_hs;
  logic           w_ar_hs;
  logic           w_r_last_hs;
  logic [APL-1:0] w_aw_sel;
  logic [APL-1:0] w_ar_sel;
  logic [WPL-1:0] w_w_sel;

  // master 1 is locked out of new grants during boot loading
  assign w_elig   = {~excl_m0, 1'b1};
  assign w_aw_req = s_awvalid & w_elig;
  assign w_ar_req = s_arvalid & w_elig;
  assign w_wr_win = (w_aw_req == 2'b11) ? ~r_wr_owner : w_aw_req[1];
  assign w_rd_win = (w_ar_req == 2'b11) ? ~r_rd_owner : w_ar_req[1];

  assign w_aw_sel = r_wr_owner ? s_aw_pl[APL +: APL] : s_aw_pl[0 +: APL];
  assign w_ar_sel = r_rd_owner ? s_ar_pl[APL +: APL] : s_ar_pl[0 +: APL];
  assign w_w_sel  = r_wr_owner ? s_w_pl[WPL +: WPL]  : s_w_pl[0 +: WPL];

  assign m_aw_pl  = w_aw_sel;
  assign m_ar_pl  = w_ar_sel;
  assign m_w_pl   = w_w_sel;
  assign m_wlast  = r_wr_owner ? s_wlast[1] : s_wlast[0];

  assign s_bresp  = m_bresp;
  assign s_rdata  = m_rdata;
  assign s_rresp  = m_rresp;
  assign s_rlast  = m_rlast;

  assign wr_grant  = r_wr_grant;
  assign rd_grant  = r_rd_grant;
  assign proto_err = r_proto_err;

  assign w_aw_hs     = (r_wr_state == W_ADDR) && m_awvalid && m_awready;
  assign w_w_hs      = (r_wr_state == W_DATA) && m_wvalid && m_wready;
  assign w_b_hs      = (r_wr_state == W_RESP) && m_bvalid && m_bready;
  assign w_ar_hs     = (r_rd_state == R_ADDR) && m_arvalid && m_arready;
  assign w_r_last_hs = (r_rd_state == R_DATA) && m_rvalid && m_rready && m_rlast;

  // ---------------------------------------------------------------- write FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_state <= W_IDLE;
    end else begin
      r_wr_state <= w_wr_state_nxt;
    end
  end

  always_comb begin
    w_wr_state_nxt = r_wr_state;
    case (r_wr_state)
      W_IDLE:  if (|w_aw_req) w_wr_state_nxt = W_ADDR;
      W_ADDR:  if (w_aw_hs) w_wr_state_nxt = W_DATA;
      W_DATA:  if (w_w_hs && m_wlast) w_wr_state_nxt = W_RESP;
      W_RESP:  if (w_b_hs) w_wr_state_nxt = W_IDLE;
      default: w_wr_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    s_awready = 2'b00;
    m_awvalid = 1'b0;
    s_wready  = 2'b00;
    m_wvalid  = 1'b0;
    s_bvalid  = 2'b00;
    m_bready  = 1'b0;
    case (r_wr_state)
      W_ADDR: begin
        m_awvalid = |(s_awvalid & r_wr_grant);
        s_awready = r_wr_grant & {2{m_awready}};
      end
      W_DATA: begin
        m_wvalid = |(s_wvalid & r_wr_grant);
        s_wready = r_wr_grant & {2{m_wready}};
      end
      W_RESP: begin
        m_bready = |(s_bready & r_wr_grant);
        s_bvalid = r_wr_grant & {2{m_bvalid}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_owner  <= 1'b1;
      r_wr_grant  <= 2'b00;
      r_wr_len    <= 8'd0;
      r_wr_cnt    <= 8'd0;
      r_proto_err <= 1'b0;
    end else begin
      if ((r_wr_state == W_IDLE) && |w_aw_req) begin
        r_wr_owner <= w_wr_win;
        r_wr_grant <= w_wr_win ? 2'b10 : 2'b01;
      end else if (w_b_hs) begin
        r_wr_grant <= 2'b00;
      end
      if (w_aw_hs) begin
        r_wr_len <= w_aw_sel[12:5];
        r_wr_cnt <= 8'd0;
      end
      // counter holds the index of the beat being accepted
      if (w_w_hs) begin
        r_wr_cnt <= r_wr_cnt + 8'd1;
        if (m_wlast ? (r_wr_cnt != r_wr_len) : (r_wr_cnt == r_wr_len)) begin
          r_proto_err <= 1'b1;
        end
      end
    end
  end

  // ----------------------------------------------------------------- read FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_state <= R_IDLE;
    end else begin
      r_rd_state <= w_rd_state_nxt;
    end
  end

  always_comb begin
    w_rd_state_nxt = r_rd_state;
    case (r_rd_state)
      R_IDLE:  if (|w_ar_req) w_rd_state_nxt = R_ADDR;
      R_ADDR:  if (w_ar_hs) w_rd_state_nxt = R_DATA;
      R_DATA:  if (w_r_last_hs) w_rd_state_nxt = R_IDLE;
      default: w_rd_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    s_arready = 2'b00;
    m_arvalid = 1'b0;
    s_rvalid  = 2'b00;
    m_rready  = 1'b0;
    case (r_rd_state)
      R_ADDR: begin
        m_arvalid = |(s_arvalid & r_rd_grant);
        s_arready = r_rd_grant & {2{m_arready}};
      end
      R_DATA: begin
        m_rready = |(s_rready & r_rd_grant);
        s_rvalid = r_rd_grant & {2{m_rvalid}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_owner <= 1'b1;
      r_rd_grant <= 2'b00;
    end else begin
      if ((r_rd_state == R_IDLE) && |w_ar_req) begin
        r_rd_owner <= w_rd_win;
        r_rd_grant <= w_rd_win ? 2'b10 : 2'b01;
      end else if (w_r_last_hs) begin
        r_rd_grant <= 2'b00;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/nac_axi_mem_arbiter.md
Name: nac_axi_mem_arbiter

Overview:
- Two-master to one-slave AXI4 arbiter that shares the DDR3 memory controller's AXI slave port.
- Master 0 is the SD loader or boot DMA; master 1 is the NAC processor core.
- Read and write directions are arbitrated independently: round-robin, with an exclusive-lock override for boot loading.
- One outstanding burst per direction; each burst is tracked to completion, and a sticky error flag reports burst-length violations.

Parameters:
- AW, 32, address width.
- DW, 32, data width (DW/8 strobe bits).
- APL, AW+13, packed address-channel payload width {addr[AW-1:0], len[7:0], size[2:0], burst[1:0]}.
- WPL, DW+DW/8, packed write-data payload width {data, strb}.

Ports:
- clk  in  1  single clock; one clock; reset is asynchronous and active-high.
- rst  in  1  reset, asynchronous, active-high.
- excl_m0  in  1  when 1, only master 0 may win new grants (boot/load phase).
- s_aw_pl  in  2*APL  master AW payloads; master i occupies slice [i*APL +: APL].
- s_awvalid  in  2  per-master AW valid.
- s_awready  out  2  per-master AW ready.
- s_w_pl  in  2*WPL  master W payloads.
- s_wlast  in  2  per-master W last.
- s_wvalid  in  2  per-master W valid.
- s_wready  out  2  per-master W ready.
- s_bresp  out  2  B response, broadcast to both masters.
- s_bvalid  out  2  per-master B valid.
- s_bready  in  2  per-master B ready.
- s_ar_pl  in  2*APL  master AR payloads.
- s_arvalid  in  2  per-master AR valid.
- s_arready  out  2  per-master AR ready.
- s_rdata  out  DW  R data, broadcast.
- s_rresp  out  2  R response, broadcast.
- s_rlast  out  1  R last, broadcast.
- s_rvalid  out  2  per-master R valid.
- s_rready  in  2  per-master R ready.
- m_aw_pl / m_awvalid / m_awready  out/out/in  APL/1/1  slave AW channel.
- m_w_pl / m_wlast / m_wvalid / m_wready  out/out/out/in  WPL/1/1/1  slave W channel.
- m_bresp / m_bvalid / m_bready  in/in/out  2/1/1  slave B channel.
- m_ar_pl / m_arvalid / m_arready  out/out/in  APL/1/1  slave AR channel.
- m_rdata / m_rresp / m_rlast / m_rvalid / m_rready  in/in/in/in/out  DW/2/1/1/1  slave R channel.
- wr_grant  out  2  one-hot write owner; 0 when idle.
- rd_grant  out  2  one-hot read owner; 0 when idle.
- proto_err  out  1  sticky flag: wlast beat count mismatched the captured awlen.

Behaviour:
- Reset (async, any state): both FSMs go to IDLE. All m_*valid, m_*ready, s_*ready and s_*valid outputs are 0. wr_grant = rd_grant = 0, proto_err = 0. Both round-robin pointers are set so that master 0 wins the first tie. An in-flight burst is abandoned with no drain.
- Eligibility: master 1 is eligible only when excl_m0 = 0. excl_m0 is sampled only in IDLE and never aborts a granted burst.
- Write FSM, WIDLE:
  - If any eligible s_awvalid is high, register a grant. On a single request, that master wins. On a tie, the master not granted last wins.
  - Go to WADDR and update the pointer. This costs 1 cycle of arbitration latency; no combinational valid-to-ready path in IDLE.
- Write FSM, WADDR:
  - m_aw_pl and m_awvalid come from the owner; s_awready[owner] = m_awready.
  - On handshake, capture len into the beat counter (cleared to 0) and go to WDATA.
- Write FSM, WDATA:
  - Forward W from the owner; s_wready[owner] = m_wready. The non-owner's wready stays 0.
  - Each W handshake increments the counter.
  - When the wlast handshake occurs: if counter != captured len, set proto_err. Go to WRESP.
  - A beat at counter == len without wlast also sets proto_err; the FSM keeps forwarding until wlast.
- Write FSM, WRESP:
  - s_bvalid[owner] = m_bvalid and m_bready = s_bready[owner].
  - On B handshake, go to WIDLE and clear wr_grant in the same edge.
  - Back-to-back bursts: WIDLE is visited for ≥1 cycle between bursts.
- Read FSM, RIDLE → RADDR: same arbitration as the write side, with its own pointer.
- Read FSM, RADDR: forward AR; on handshake go to RDATA.
- Read FSM, RDATA:
  - s_rvalid[owner] = m_rvalid and m_rready = s_rready[owner]. The non-owner's rvalid stays 0.
  - On handshake with m_rlast = 1, go to RIDLE.
- Directions are independent: master 0 may hold the write grant while master 1 holds the read grant, with no interaction.
- Payloads toward the slave are muxed from the current owner. The m_ outputs hold the last owner's payload when idle; only the valids are guaranteed 0.
- The write direction ignores awlen; only proto_err depends on it. Slave-side ID is fixed to 0 by the instantiating wrapper.

Test Plan:
- Single write: m0 issues a 4-beat write (awlen=3) with excl_m0=0 → wr_grant=01 one cycle after awvalid; 4 W beats pass; s_bvalid[0] follows m_bvalid; then wr_grant=00 and proto_err=0.
- Tie: m0 and m1 both assert awvalid in the same cycle, bursts of len 0, repeated twice → grant order m0, m1, m0, m1 with ≥1 idle cycle between bursts.
- Exclusive lock: excl_m0=1, m1 asserts arvalid → s_arready[1] stays 0 for 100 cycles. Deassert excl_m0 → rd_grant=10 within 2 cycles.
- Concurrent directions: m0 writes 8 beats while m1 reads 16 beats with random m_rvalid/m_wready stalls → both complete; rdata reaches only s_rvalid[1]; wr_grant=01 and rd_grant=10 overlap.
- Bad length: m1 sends awlen=3 but asserts wlast on beat 2 → proto_err=1 after that edge; B still forwarded; proto_err stays 1 through later good bursts.
- Reset mid-burst: assert rst during WDATA beat 2 → all valid/ready outputs 0 and grants 00 immediately (async). After release, a new m1 write completes normally.
